// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings for the decode-stage branch hazard controller.
// Also holds the register-match helper used by hazard detection.
package branch_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic SEL_BEQ = 1'b0;
  localparam logic SEL_BNE = 1'b1;

  // Register 0 is hard-wired, so a producer targeting it never creates a hazard.
  function automatic logic reg_hit(input logic [4:0] rd,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       use_rs,
                                   input logic       use_rt);
    return (rd != '0) && ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Decode-stage branch bus: operands, producer info, control outputs and statistics.
interface branch_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       pcsrc;
  logic             beq_or_bne;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [31:0]      data1;
  logic [31:0]      data2;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             mem_memread;
  logic [4:0]       mem_rd;
  logic             stall;
  logic             flush_ifid;
  logic             pc_redirect;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output pcsrc, beq_or_bne, id_rs, id_rt, data1, data2,
           ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
    input  stall, flush_ifid, pc_redirect, branch_cnt, taken_cnt, stall_cnt
  );

  modport slave (
    input  pcsrc, beq_or_bne, id_rs, id_rt, data1, data2,
           ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
    output stall, flush_ifid, pc_redirect, branch_cnt, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl_branch_detect.sv
// Decode-stage equality comparator: verdict for conditional branches only.
module branch_detect
  import branch_hazard_ctrl_pkg::*;
(
  input  logic [1:0]  pcsrc,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        beq_or_bne,
  output logic        branch_bool
);

  always_comb begin
    branch_bool = (pcsrc == PCSRC_BR) && ((data1 == data2) ^ (beq_or_bne == SEL_BNE));
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch/jump resolution in ID: hazard stall sequencing, redirect/flush and
// saturating branch/stall statistics.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       use_rs, use_rt;
  logic [1:0] need;
  logic       br_bool;
  logic       taken;
  logic       resolve;
  logic       stall;
  logic       redirect;

  branch_detect u_branch_detect (
    .pcsrc       (bus.pcsrc),
    .data1       (bus.data1),
    .data2       (bus.data2),
    .beq_or_bne  (bus.beq_or_bne),
    .branch_bool (br_bool)
  );

  always_comb begin
    use_rs = (bus.pcsrc == PCSRC_BR) || (bus.pcsrc == PCSRC_JR);
    use_rt = (bus.pcsrc == PCSRC_BR);

    if (bus.ex_memread && reg_hit(bus.ex_rd, bus.id_rs, bus.id_rt, use_rs, use_rt))
      need = 2'd2;
    else if (bus.ex_regwrite && reg_hit(bus.ex_rd, bus.id_rs, bus.id_rt, use_rs, use_rt))
      need = 2'd1;
    else if (bus.mem_memread && reg_hit(bus.mem_rd, bus.id_rs, bus.id_rt, use_rs, use_rt))
      need = 2'd1;
    else
      need = 2'd0;

    taken = br_bool || (bus.pcsrc == PCSRC_J) || (bus.pcsrc == PCSRC_JR);
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stall      = 1'b0;
    redirect   = 1'b0;
    resolve    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (need == 2'd0) begin
          resolve  = 1'b1;
          redirect = taken;
        end else begin
          // The RUN cycle already counts as the first stall cycle, so the
          // counter holds the remaining stalls (need-1, at most 1).
          stall      = 1'b1;
          hold_cnt_d = (need == 2'd2);
          state_d    = (need == 2'd2) ? ST_HOLD : ST_RUN;
        end
      end
      ST_HOLD: begin
        stall      = 1'b1;
        hold_cnt_d = hold_cnt_q - 1'b1;
        if (hold_cnt_d == 1'b0) state_d = ST_RUN;
      end
      default: begin
        state_d    = ST_RUN;
        hold_cnt_d = 1'b0;
      end
    endcase

    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (resolve && (bus.pcsrc != PCSRC_SEQ) && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    if (redirect && (taken_cnt_q != '1))
      taken_cnt_d = taken_cnt_q + CNT_ONE;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      hold_cnt_q   <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.pc_redirect = redirect;
  assign bus.flush_ifid  = redirect;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.taken_cnt   = taken_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: a 16-bit-counter instance for the
// functional sequences and a 4-bit-counter instance for saturation.
module tb_branch_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  branch_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

  branch_hazard_ctrl #(.CNT_W(16)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  branch_hazard_ctrl #(.CNT_W(4))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic f, input logic r);
    chk({tag, ".stall"},       32'(bus_a.stall),       32'(s));
    chk({tag, ".flush_ifid"},  32'(bus_a.flush_ifid),  32'(f));
    chk({tag, ".pc_redirect"}, 32'(bus_a.pc_redirect), 32'(r));
  endtask

  task automatic chk_cnt(input string tag, input int b, input int t, input int s);
    chk({tag, ".branch_cnt"}, 32'(bus_a.branch_cnt), b);
    chk({tag, ".taken_cnt"},  32'(bus_a.taken_cnt),  t);
    chk({tag, ".stall_cnt"},  32'(bus_a.stall_cnt),  s);
  endtask

  task automatic idle_a();
    bus_a.pcsrc = 2'b00; bus_a.beq_or_bne = 1'b0;
    bus_a.id_rs = '0; bus_a.id_rt = '0; bus_a.data1 = '0; bus_a.data2 = '0;
    bus_a.ex_regwrite = 1'b0; bus_a.ex_memread = 1'b0; bus_a.ex_rd = '0;
    bus_a.mem_memread = 1'b0; bus_a.mem_rd = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_a();
    bus_b.pcsrc = 2'b00; bus_b.beq_or_bne = 1'b0;
    bus_b.id_rs = '0; bus_b.id_rt = '0; bus_b.data1 = '0; bus_b.data2 = '0;
    bus_b.ex_regwrite = 1'b0; bus_b.ex_memread = 1'b0; bus_b.ex_rd = '0;
    bus_b.mem_memread = 1'b0; bus_b.mem_rd = '0;

    // Reset state
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_cnt("reset", 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Branch with no hazard: taken beq, same-cycle redirect
    @(negedge clk);
    bus_a.pcsrc = 2'b01; bus_a.beq_or_bne = 1'b0;
    bus_a.id_rs = 5'd1; bus_a.id_rt = 5'd2;
    bus_a.data1 = 32'h1234; bus_a.data2 = 32'h1234;
    #1 chk_ctl("nohaz", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_a();
    #1 chk_ctl("nohaz_idle", 1'b0, 1'b0, 1'b0);
    chk_cnt("nohaz", 1, 1, 0);

    // ALU hazard on rs: one stall, then not-taken bne
    @(negedge clk);
    bus_a.pcsrc = 2'b01; bus_a.beq_or_bne = 1'b1;
    bus_a.id_rs = 5'd8; bus_a.id_rt = 5'd3;
    bus_a.data1 = 32'd5; bus_a.data2 = 32'd5;
    bus_a.ex_regwrite = 1'b1; bus_a.ex_rd = 5'd8;
    #1 chk_ctl("alu_stall", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.ex_regwrite = 1'b0; bus_a.ex_rd = '0;
    #1 chk_ctl("alu_resolve", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle_a();
    #1 chk_cnt("alu", 2, 1, 1);

    // Load-use hazard on rt: two stalls (RUN then HOLD), HOLD ignores inputs
    @(negedge clk);
    bus_a.pcsrc = 2'b01; bus_a.beq_or_bne = 1'b0;
    bus_a.id_rs = 5'd4; bus_a.id_rt = 5'd9;
    bus_a.data1 = 32'd7; bus_a.data2 = 32'd7;
    bus_a.ex_regwrite = 1'b1; bus_a.ex_memread = 1'b1; bus_a.ex_rd = 5'd9;
    #1 chk_ctl("load_run", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.ex_regwrite = 1'b0; bus_a.ex_memread = 1'b0; bus_a.ex_rd = '0;
    #1 chk_ctl("load_hold", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_ctl("load_resolve", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_a();
    #1 chk_cnt("load", 3, 2, 3);

    // jr with a MEM load to rs=31: one stall, then redirect
    @(negedge clk);
    bus_a.pcsrc = 2'b11; bus_a.id_rs = 5'd31; bus_a.id_rt = 5'd0;
    bus_a.mem_memread = 1'b1; bus_a.mem_rd = 5'd31;
    #1 chk_ctl("jr_stall", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.mem_memread = 1'b0; bus_a.mem_rd = '0;
    #1 chk_ctl("jr_resolve", 1'b0, 1'b1, 1'b1);

    // jr with rs=0 and MEM load to r0: no stall
    @(negedge clk);
    bus_a.pcsrc = 2'b11; bus_a.id_rs = 5'd0;
    bus_a.mem_memread = 1'b1; bus_a.mem_rd = 5'd0;
    #1 chk_ctl("jr_r0", 1'b0, 1'b1, 1'b1);

    // jr does not read rt: EX writer of rt is no hazard
    @(negedge clk);
    bus_a.pcsrc = 2'b11; bus_a.id_rs = 5'd5; bus_a.id_rt = 5'd6;
    bus_a.mem_memread = 1'b0; bus_a.mem_rd = '0;
    bus_a.ex_regwrite = 1'b1; bus_a.ex_rd = 5'd6;
    #1 chk_ctl("jr_rt_ignored", 1'b0, 1'b1, 1'b1);

    // Jump reads no operands: EX load to rs is no hazard
    @(negedge clk);
    bus_a.pcsrc = 2'b10; bus_a.id_rs = 5'd7;
    bus_a.ex_regwrite = 1'b1; bus_a.ex_memread = 1'b1; bus_a.ex_rd = 5'd7;
    #1 chk_ctl("j_noops", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_a();
    #1 chk_cnt("jumps", 7, 6, 4);

    // Reset asserted mid-HOLD
    @(negedge clk);
    bus_a.pcsrc = 2'b01; bus_a.id_rs = 5'd2; bus_a.id_rt = 5'd9;
    bus_a.ex_regwrite = 1'b1; bus_a.ex_memread = 1'b1; bus_a.ex_rd = 5'd9;
    #1 chk_ctl("rst_run", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle_a();
    #1 chk_ctl("rst_hold", 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_ctl("rst_async", 1'b0, 1'b0, 1'b0);
    chk_cnt("rst_async", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_a.pcsrc = 2'b01; bus_a.beq_or_bne = 1'b0;
    bus_a.id_rs = 5'd3; bus_a.id_rt = 5'd4;
    bus_a.data1 = 32'hCAFE; bus_a.data2 = 32'hCAFE;
    #1 chk_ctl("post_rst", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_a();
    #1 chk_cnt("post_rst", 1, 1, 0);

    // Saturation on 4-bit counters: 20 taken jumps
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_b.pcsrc = 2'b10;
      if (i == 15) begin
        #1 chk("sat_taken_at15", 32'(bus_b.taken_cnt), 32'd15);
      end
    end
    @(negedge clk);
    bus_b.pcsrc = 2'b00;
    #1;
    chk("sat_taken_cnt",  32'(bus_b.taken_cnt),  32'd15);
    chk("sat_branch_cnt", 32'(bus_b.branch_cnt), 32'd15);
    chk("sat_stall_cnt",  32'(bus_b.stall_cnt),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Sequences branch and jump resolution in the decode stage of the five-stage MIPS pipeline. Compares the decode-stage branch operand registers against in-flight destinations in EX and MEM, holds PC and IF/ID for the required number of cycles, then applies the comparator verdict as a PC redirect plus IF/ID flush. It wraps the decode-stage equality comparator and keeps saturating branch/stall statistics for the AES performance runs.

## Interface
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pcsrc  in  2  decode-stage PC source: 00 sequential, 01 conditional branch, 10 jump (no operands), 11 jr (reads rs)
- beq_or_bne  in  1  0 = beq, 1 = bne
- id_rs, id_rt  in  5 each  decode-stage source register numbers
- data1, data2  in  32 each  forwarded rs/rt values presented to the comparator
- ex_regwrite, ex_memread  in  1 each  EX-stage instruction writes a register / is a load
- ex_rd  in  5  EX-stage destination register
- mem_memread  in  1  MEM-stage instruction is a load
- mem_rd  in  5  MEM-stage destination register
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush_ifid  out  1  load a NOP into IF/ID
- pc_redirect  out  1  select branch/jump target for next PC
- branch_cnt, taken_cnt, stall_cnt  out  CNT_W each  statistics

## Operation
- Operand use: pcsrc 01 reads rs and rt; pcsrc 11 reads rs only; pcsrc 10 and 00 read none. Register 0 never matches.
- Hazard need (first match wins): EX load matching a used operand -> 2; EX regwrite (non-load) matching -> 1; MEM load matching -> 1; otherwise 0.
- FSM states: RUN, HOLD.
- RUN, need 0: resolve this cycle.
  - pcsrc 01: taken = (data1==data2) XOR beq_or_bne.
  - pcsrc 10/11: taken = 1.
  - taken -> pc_redirect=1, flush_ifid=1.
- RUN, need >0: stall=1. Load hold counter with need-1, then go to HOLD; if need-1 is 0, remain in RUN. No redirect is issued.
- HOLD: stall=1 and the counter decrements. At 0, return to RUN, where the now-hazard-free branch resolves.
- The hold counter is 1 bit wide because the maximum need is 2.
- Statistics (saturate at all-ones, never wrap):
  - branch_cnt +1 on each resolution with pcsrc!=00.
  - taken_cnt +1 on each taken resolution.
  - stall_cnt +1 on each cycle with stall=1.
- stall and pc_redirect are never asserted together.
- flush_ifid implies pc_redirect.

## Timing
- stall, flush_ifid and pc_redirect are combinational from the state, the counter and the current inputs. Hazard detection, resolution and redirect all happen in the same cycle.
- Latency from branch entering ID to redirect:
  - 0 cycles with no hazard.
  - 1 cycle for an EX ALU producer or a MEM load producer.
  - 2 cycles for an EX load producer.
- Counters update on the clock edge that ends the qualifying cycle.
- Reset, asynchronous at any time including mid-HOLD:
  - state returns to RUN and the hold counter to 0.
  - all statistics counters clear to 0.
  - stall=0, flush_ifid=0 and pc_redirect=0 immediately, provided pcsrc=00 while reset is asserted.
  - the first edge after release operates normally.
- In HOLD, the decode inputs are stable because IF/ID is held. The block does not re-sample the hazard until it is back in RUN.

## Structure
- Shared package constants:
  - PCSRC_SEQ/BR/J/JR encodings.
  - state encoding RUN/HOLD.
  - beq/bne select values.
- Sub-module: the existing branch_detect comparator (pcsrc, data1, data2, beq_or_bne -> branch_bool) is instantiated for the pcsrc 01 verdict.
- The FSM, hazard compare and counters sit in this block.

## Test plan
- Branch with no hazard: pcsrc=01, beq, data1=data2=0x1234, no producers -> same-cycle pc_redirect=1, flush_ifid=1, stall=0; branch_cnt=1, taken_cnt=1.
- ALU hazard: EX regwrite, ex_rd=8, id_rs=8 -> one stall cycle, stall_cnt=1. Next cycle with EX cleared, bne, data1=5, data2=5 -> not taken, no flush.
- Load-use hazard: EX memread, ex_rd=9, id_rt=9 -> stall for 2 cycles (RUN then HOLD), then resolve; stall_cnt=2.
- jr with a MEM load to rs=31 -> 1 stall, then redirect. Same scenario with rd=0 -> no stall.
- Saturation: CNT_W=4, 20 taken branches -> taken_cnt=15, no wrap.
- Reset asserted in HOLD -> stall drops immediately and all counters read 0. After release, a fresh hazard-free branch resolves in 0 cycles.
